// File: rtl/csr_file_pkg.sv
// csr_file_pkg: CSR addresses, op codes, status/interrupt bit positions.
// Shared by the CSR unit, its counter sub-block and the access interface.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    OP_RD = 2'b00,
    OP_RW = 2'b01,
    OP_RS = 2'b10,
    OP_RC = 2'b11
  } csr_op_e;

  localparam int MS_MIE  = 3;
  localparam int MS_MPIE = 7;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: CSR instruction access bus (req/op/addr/wdata in,
// rdata/illegal back); master = execute stage, slave = CSR unit.
interface csr_file_if #(
  parameter int XLEN = 64
);
  logic            csr_req_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;

  modport master (
    output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_file_counter.sv
// csr_counter: 64-bit wrapping counter; inc enables +1, we_lo/we_hi load
// the addressed 32-bit half(s) of wdata and suppress the increment.
module csr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [63:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) value[31:0]  <= wdata[31:0];
      if (we_hi) value[63:32] <= wdata[63:32];
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs, trap/mret sequencing, irq arbitration, counters.
// Ports: clk/rst_n, bus (CSR access), trap/mret/retire/irq in, irq/trap/status out.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] HART_ID    = '0,
  parameter logic [XLEN-1:0] MTVEC_INIT = XLEN'(32'h8000_0000),
  parameter logic [XLEN-1:0] MISA_VAL   = (XLEN == 64) ?
    XLEN'(64'h8000_0000_0000_0100) : XLEN'(64'h4000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_file_if.slave       bus,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic            instr_retire_i,
  input  logic            ext_irq_i,
  input  logic            sft_irq_i,
  input  logic            tmr_irq_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mie_o
);

  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mepc_q;
  logic [XLEN-1:0] mcause_q, mtval_q, mscratch_q;
  logic [2:0]      mip_q;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] mstatus, mip, rd, wval;
  logic            known, wr_try, ro, we;
  logic [XLEN-1:0] pend, tv_base;
  logic [3:0]      code;
  logic [63:0]     cnt_wdata;
  logic            cyc_lo, cyc_hi, ins_lo, ins_hi;

  assign mstatus = XLEN'({2'b11, 3'b000, st_mpie, 3'b000, st_mie, 3'b000});
  assign mip = XLEN'({mip_q[2], 3'b000, mip_q[1], 3'b000, mip_q[0], 3'b000});

  always_comb begin
    rd    = '0;
    known = 1'b1;
    unique case (bus.csr_addr_i)
      CSR_MSTATUS:  rd = mstatus;
      CSR_MISA:     rd = MISA_VAL;
      CSR_MIE:      rd = mie_q;
      CSR_MTVEC:    rd = mtvec_q;
      CSR_MSCRATCH: rd = mscratch_q;
      CSR_MEPC:     rd = mepc_q;
      CSR_MCAUSE:   rd = mcause_q;
      CSR_MTVAL:    rd = mtval_q;
      CSR_MIP:      rd = mip;
      CSR_MCYCLE:   rd = XLEN'(mcycle);
      CSR_MINSTRET: rd = XLEN'(minstret);
      CSR_MCYCLEH:
        if (XLEN == 32) rd = XLEN'(mcycle[63:32]);
        else            known = 1'b0;
      CSR_MINSTRETH:
        if (XLEN == 32) rd = XLEN'(minstret[63:32]);
        else            known = 1'b0;
      CSR_MHARTID:  rd = HART_ID;
      default:      known = 1'b0;
    endcase
  end

  always_comb begin
    wval = rd;
    unique case (bus.csr_op_i)
      OP_RW:   wval = bus.csr_wdata_i;
      OP_RS:   wval = rd | bus.csr_wdata_i;
      OP_RC:   wval = rd & ~bus.csr_wdata_i;
      default: wval = rd;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal on RO CSRs
  assign wr_try = (bus.csr_op_i == OP_RW) ||
                  ((bus.csr_op_i != OP_RD) && (|bus.csr_wdata_i));
  assign ro = (bus.csr_addr_i[11:10] == 2'b11);
  assign bus.csr_rdata_o   = rd;
  assign bus.csr_illegal_o = bus.csr_req_i && (!known || (wr_try && ro));
  assign we = bus.csr_req_i && wr_try && known && !ro && !trap_i && !mret_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b1;
      st_mpie    <= 1'b0;
      mie_q      <= MIE_MASK;
      mtvec_q    <= MTVEC_INIT;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      mip_q      <= '0;
    end else begin
      mip_q <= {ext_irq_i, tmr_irq_i, sft_irq_i};
      if (trap_i) begin
        mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_val_i;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (we) begin
        case (bus.csr_addr_i)
          CSR_MSTATUS: begin
            st_mie  <= wval[MS_MIE];
            st_mpie <= wval[MS_MPIE];
          end
          CSR_MIE:      mie_q <= wval & MIE_MASK;
          // reserved MODE values keep the old MODE but still take BASE
          CSR_MTVEC:    mtvec_q <= {wval[XLEN-1:2],
                                    wval[1] ? mtvec_q[1:0] : wval[1:0]};
          CSR_MSCRATCH: mscratch_q <= wval;
          CSR_MEPC:     mepc_q <= {wval[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause_q <= wval;
          CSR_MTVAL:    mtval_q <= wval;
          default: ;
        endcase
      end
    end
  end

  assign pend = mip & mie_q;
  assign irq_req_o = st_mie && (|pend);

  always_comb begin
    code = '0;
    priority case (1'b1)
      pend[IRQ_MEI]: code = CODE_MEI;
      pend[IRQ_MSI]: code = CODE_MSI;
      pend[IRQ_MTI]: code = CODE_MTI;
      default:       code = '0;
    endcase
  end

  assign irq_cause_o = irq_req_o ? {1'b1, (XLEN-1)'(code)} : '0;

  assign tv_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_vec_o =
    (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1]) ?
    tv_base + {trap_cause_i[XLEN-3:0], 2'b00} : tv_base;

  assign mepc_o    = mepc_q;
  assign mstatus_o = mstatus;
  assign mie_o     = mie_q;

  // XLEN=64 writes both halves via 0xB00; XLEN=32 splits lo/hi addresses
  assign cnt_wdata = {wval[XLEN-1:XLEN-32], wval[31:0]};
  assign cyc_lo = we && (bus.csr_addr_i == CSR_MCYCLE);
  assign ins_lo = we && (bus.csr_addr_i == CSR_MINSTRET);
  assign cyc_hi = (XLEN == 64) ? cyc_lo :
                  we && (bus.csr_addr_i == CSR_MCYCLEH);
  assign ins_hi = (XLEN == 64) ? ins_lo :
                  we && (bus.csr_addr_i == CSR_MINSTRETH);

  csr_counter u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .we_lo (cyc_lo),
    .we_hi (cyc_hi),
    .wdata (cnt_wdata),
    .value (mcycle)
  );

  csr_counter u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_retire_i),
    .we_lo (ins_lo),
    .we_hi (ins_hi),
    .wdata (cnt_wdata),
    .value (minstret)
  );

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed bench for csr_file (XLEN=32) with a CSR-map model
// compared every cycle plus hand-computed literal expectations.
module tb_csr_file;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        retire = 1'b0;
  logic        ext = 1'b0;
  logic        sft = 1'b0;
  logic        tmr = 1'b0;
  logic [31:0] cause = '0;
  logic [31:0] pc = '0;
  logic [31:0] tval = '0;
  logic        irq_req;
  logic [31:0] irq_cause, trap_vec, mepc, mstatus, mie;

  int total = 0;
  int bad = 0;

  csr_file_if #(.XLEN(XLEN)) bus ();

  csr_file #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .trap_i         (trap_i),
    .trap_cause_i   (cause),
    .trap_pc_i      (pc),
    .trap_val_i     (tval),
    .mret_i         (mret_i),
    .instr_retire_i (retire),
    .ext_irq_i      (ext),
    .sft_irq_i      (sft),
    .tmr_irq_i      (tmr),
    .irq_req_o      (irq_req),
    .irq_cause_o    (irq_cause),
    .trap_vec_o     (trap_vec),
    .mepc_o         (mepc),
    .mstatus_o      (mstatus),
    .mie_o          (mie)
  );

  always #5 clk = ~clk;

  // ---- model: architectural CSR state ----
  logic        m_mie, m_mpie;
  logic [31:0] m_mier, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscr, m_mip;
  logic [63:0] m_cyc, m_ins;
  logic [32:0] cr;

  task automatic mreset();
    m_mie = 1'b1; m_mpie = 1'b0;
    m_mier = 32'h888; m_mtvec = 32'h8000_0000;
    m_mepc = '0; m_mcause = '0; m_mtval = '0; m_mscr = '0; m_mip = '0;
    m_cyc = '0; m_ins = '0;
  endtask

  function automatic logic [31:0] m_status();
    return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
  endfunction

  // {known, value}
  function automatic logic [32:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, m_status()};
      12'h301: return {1'b1, 32'h4000_0100};
      12'h304: return {1'b1, m_mier};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscr};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      12'h344: return {1'b1, m_mip};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB02: return {1'b1, m_ins[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB82: return {1'b1, m_ins[63:32]};
      12'hF14: return {1'b1, 32'h0};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic logic is_wr(input logic [1:0] op, input logic [31:0] d);
    return (op == 2'b01) || (op != 2'b00 && d != 0);
  endfunction

  function automatic logic [31:0] exp_cause();
    logic [31:0] p;
    p = m_mip & m_mier;
    if (!m_mie || p == 0) return 32'h0;
    if (p[11]) return 32'h8000_000B;
    if (p[3])  return 32'h8000_0003;
    return 32'h8000_0007;
  endfunction

  function automatic logic [31:0] exp_tv();
    logic [31:0] b;
    b = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && cause[31])
      return b + ((cause & 32'h7FFF_FFFF) << 2);
    return b;
  endfunction

  task automatic mstep();
    logic [32:0] r;
    logic [31:0] wv, wd;
    logic [63:0] nc, ni;
    logic ok;
    logic [11:0] a;
    a = bus.csr_addr_i;
    r = mread(a);
    wd = bus.csr_wdata_i;
    case (bus.csr_op_i)
      2'b01:   wv = wd;
      2'b10:   wv = r[31:0] | wd;
      default: wv = r[31:0] & ~wd;
    endcase
    ok = bus.csr_req_i && is_wr(bus.csr_op_i, wd) && r[32] &&
         a[11:10] != 2'b11 && !trap_i && !mret_i;
    nc = m_cyc + 64'd1;
    ni = m_ins + (retire ? 64'd1 : 64'd0);
    if (trap_i) begin
      m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = tval;
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (mret_i) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (ok) begin
      case (a)
        12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
        12'h304: m_mier = wv & 32'h888;
        12'h305: m_mtvec = (wv[1:0] >= 2) ? {wv[31:2], m_mtvec[1:0]} : wv;
        12'h340: m_mscr = wv;
        12'h341: m_mepc = wv & ~32'h3;
        12'h342: m_mcause = wv;
        12'h343: m_mtval = wv;
        12'hB00: nc = {m_cyc[63:32], wv};
        12'hB80: nc = {wv, m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], wv};
        12'hB82: ni = {wv, m_ins[31:0]};
        default: ;
      endcase
    end
    m_cyc = nc;
    m_ins = ni;
    m_mip = (ext ? 32'h800 : 0) | (sft ? 32'h8 : 0) | (tmr ? 32'h80 : 0);
  endtask

  always @(posedge clk) begin
    if (!rst_n) mreset();
    else mstep();
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    cr = mread(bus.csr_addr_i);
    chk("rdata", bus.csr_rdata_o, cr[31:0]);
    chk("illegal", 32'(bus.csr_illegal_o),
        32'(bus.csr_req_i && (!cr[32] ||
            (is_wr(bus.csr_op_i, bus.csr_wdata_i) &&
             bus.csr_addr_i[11:10] == 2'b11))));
    chk("irq_req", 32'(irq_req), 32'(exp_cause() != 0));
    chk("irq_cause", irq_cause, exp_cause());
    chk("trap_vec", trap_vec, exp_tv());
    chk("mepc", mepc, m_mepc);
    chk("mstatus", mstatus, m_status());
    chk("mie", mie, m_mier);
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] d);
    bus.csr_req_i = 1'b1; bus.csr_op_i = op;
    bus.csr_addr_i = a; bus.csr_wdata_i = d;
  endtask

  task automatic idle();
    bus.csr_req_i = 1'b0; bus.csr_op_i = 2'b00;
    bus.csr_addr_i = '0; bus.csr_wdata_i = '0;
    trap_i = 1'b0; mret_i = 1'b0;
  endtask

  task automatic rd_lit(input logic [11:0] a, input logic [31:0] e,
                        input string n);
    csr(2'b00, a, 32'h0);
    #1;
    chk(n, bus.csr_rdata_o, e);
  endtask

  initial begin
    idle();
    mreset();
    repeat (3) @(posedge clk);
    rd_lit(12'h300, 32'h1808, "rst_mstatus");
    rd_lit(12'h304, 32'h888, "rst_mie");
    rd_lit(12'h305, 32'h8000_0000, "rst_mtvec");
    rd_lit(12'h7C0, 32'h0, "rd_unknown");
    chk("ill_unknown", 32'(bus.csr_illegal_o), 32'h1);
    rd_lit(12'h301, 32'h4000_0100, "misa");
    #2 rst_n = 1'b1;
    tick();

    csr(2'b01, 12'h305, 32'h8000_0003); tick();
    rd_lit(12'h305, 32'h8000_0000, "mtvec_mode3");
    csr(2'b01, 12'h305, 32'h8000_0001); tick();
    idle(); trap_i = 1'b1; cause = 32'h8000_0007; pc = 32'h2000;
    #1 chk("tvec_vectored", trap_vec, 32'h8000_001C);
    tick();
    idle(); mret_i = 1'b1; tick();

    idle(); trap_i = 1'b1; cause = 32'h2; pc = 32'h1006; tval = 32'hDEAD;
    #1 chk("tvec_exc", trap_vec, 32'h8000_0000);
    tick(); idle();
    chk("trap_mepc", mepc, 32'h1004);
    chk("trap_mstatus", mstatus, 32'h1880);
    rd_lit(12'h342, 32'h2, "trap_mcause");
    rd_lit(12'h343, 32'hDEAD, "trap_mtval");
    idle(); mret_i = 1'b1; tick(); idle();
    chk("mret_mstatus", mstatus, 32'h1888);

    ext = 1'b1; tmr = 1'b1;
    #1 chk("irq_lag", 32'(irq_req), 32'h0);
    tick();
    chk("irq_req", 32'(irq_req), 32'h1);
    chk("irq_mei", irq_cause, 32'h8000_000B);
    csr(2'b11, 12'h304, 32'h800); tick(); idle();
    chk("mie_rc", mie, 32'h88);
    chk("irq_mti", irq_cause, 32'h8000_0007);
    sft = 1'b1; tick();
    chk("irq_msi", irq_cause, 32'h8000_0003);
    csr(2'b11, 12'h300, 32'h8); tick(); idle();
    chk("irq_masked", 32'(irq_req), 32'h0);
    chk("irq_cause0", irq_cause, 32'h0);
    csr(2'b10, 12'h300, 32'h8); tick();
    ext = 1'b0; tmr = 1'b0; sft = 1'b0;
    csr(2'b01, 12'h304, 32'hFFFF_FFFF); tick(); idle();
    chk("mie_warl", mie, 32'h888);

    trap_i = 1'b1; mret_i = 1'b1; cause = 32'h5; pc = 32'h3000; tval = 0;
    csr(2'b01, 12'h341, 32'h40); tick(); idle();
    chk("trap_wins", mepc, 32'h3000);
    mret_i = 1'b1; csr(2'b01, 12'h341, 32'h40); tick(); idle();
    chk("mret_wins", mepc, 32'h3000);
    csr(2'b01, 12'h341, 32'h47); tick(); idle();
    chk("mepc_align", mepc, 32'h44);
    csr(2'b01, 12'hF14, 32'h5);
    #1 chk("ill_ro", 32'(bus.csr_illegal_o), 32'h1);
    tick();
    rd_lit(12'hF14, 32'h0, "hartid");
    csr(2'b10, 12'hF14, 32'h0);
    #1 chk("ro_rs0", 32'(bus.csr_illegal_o), 32'h0);
    csr(2'b01, 12'h344, 32'hFFF);
    #1 chk("mip_wr", 32'(bus.csr_illegal_o), 32'h0);
    tick();
    rd_lit(12'h344, 32'h0, "mip_ro");
    csr(2'b01, 12'h301, 32'h0); tick();
    rd_lit(12'h301, 32'h4000_0100, "misa_ro");
    csr(2'b01, 12'h305, 32'h8000_0102); tick();
    rd_lit(12'h305, 32'h8000_0101, "mtvec_mode2");
    csr(2'b01, 12'h340, 32'h1234); tick();
    csr(2'b10, 12'h340, 32'hF_0000); tick();
    rd_lit(12'h340, 32'hF_1234, "scr_rs");
    csr(2'b11, 12'h340, 32'h34); tick();
    rd_lit(12'h340, 32'hF_1200, "scr_rc");
    csr(2'b01, 12'h300, 32'hFFFF_FFFF); tick();
    rd_lit(12'h300, 32'h1888, "ms_warl1");
    csr(2'b01, 12'h300, 32'h0); tick();
    rd_lit(12'h300, 32'h1800, "ms_warl0");
    csr(2'b01, 12'h300, 32'h8); tick();

    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    rd_lit(12'hB00, 32'hFFFF_FFFF, "cyc_wr");
    rd_lit(12'hB80, 32'h0, "cyc_hi_hold");
    tick();
    rd_lit(12'hB00, 32'h0, "cyc_carry_lo");
    rd_lit(12'hB80, 32'h1, "cyc_carry_hi");
    retire = 1'b1;
    repeat (5) tick();
    retire = 1'b0;
    rd_lit(12'hB02, 32'h5, "instret5");
    rd_lit(12'hB82, 32'h0, "instret5_hi");
    csr(2'b01, 12'hB80, 32'hFFFF_FFFF); tick();
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    rd_lit(12'hB80, 32'hFFFF_FFFF, "cyc_hi_wr");
    rd_lit(12'hB00, 32'hFFFF_FFFF, "cyc_lo_wr");
    tick();
    rd_lit(12'hB00, 32'h0, "cyc_wrap_lo");
    rd_lit(12'hB80, 32'h0, "cyc_wrap_hi");
    retire = 1'b1;
    csr(2'b01, 12'hB02, 32'h100); tick();
    retire = 1'b0;
    rd_lit(12'hB02, 32'h100, "instret_wr");
    idle();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
